// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks pending register writers in the
// downstream stages and raises stall for data hazards and post-branch bubbles.
module hazard_scoreboard #(
  parameter int REG_W      = 3,
  parameter int DEPTH      = 3,
  parameter int FWD_EN     = 0,
  parameter int BR_BUBBLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_load,
  input  logic             id_branch,
  output logic             stall,
  output logic [15:0]      stall_cnt
);

  localparam logic [3:0]  BR_LOAD = 4'(BR_BUBBLES);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_load;
  logic [REG_W-1:0] ent_dest [DEPTH];

  logic [DEPTH-1:0] rs_match;
  logic [DEPTH-1:0] rt_match;
  logic             data_hazard;
  logic [3:0]       br_cnt;
  logic             br_accept;

  // Entry 0 mirrors the instruction leaving decode; a stall injects a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      ent_load  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ent_dest[k] <= '0;
      end
    end else begin
      if (stall) begin
        ent_valid[0] <= 1'b0;
        ent_load[0]  <= 1'b0;
        ent_dest[0]  <= '0;
      end else begin
        ent_valid[0] <= id_valid & id_wr;
        ent_load[0]  <= id_load;
        ent_dest[0]  <= id_dest;
      end
      for (int k = 1; k < DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_dest[k]  <= ent_dest[k-1];
      end
    end
  end

  always_comb begin
    rs_match = '0;
    rt_match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rs_match[k] = ent_valid[k] & id_use_rs & (id_rs == ent_dest[k]);
      rt_match[k] = ent_valid[k] & id_use_rt & (id_rt == ent_dest[k]);
    end
  end

  // With forwarding only a load still in EX cannot supply its result in time.
  always_comb begin
    data_hazard = 1'b0;
    if (FWD_EN == 0) begin
      data_hazard = |(rs_match | rt_match);
    end else begin
      data_hazard = (rs_match[0] | rt_match[0]) & ent_load[0];
    end
  end

  assign stall     = ~rst & ((id_valid & data_hazard) | (br_cnt != 4'd0));
  assign br_accept = id_valid & id_branch & ~stall;

  // A branch held by a data stall only arms the bubble counter once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt <= 4'd0;
    end else if (br_accept) begin
      br_cnt <= BR_LOAD;
    end else if (br_cnt != 4'd0) begin
      br_cnt <= br_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: three scoreboard configurations share one decode stream
// (no forwarding, load-use forwarding, 15-bubble branches for saturation).
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_wr;
  logic [2:0] id_dest;
  logic       id_load;
  logic       id_branch;

  logic        stall_nf;
  logic [15:0] cnt_nf;
  logic        stall_fw;
  logic [15:0] cnt_fw;
  logic        stall_br;
  logic [15:0] cnt_br;

  int checkCount;
  int passCount;

  hazard_scoreboard #(.REG_W(3), .DEPTH(3), .FWD_EN(0), .BR_BUBBLES(2)) u_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr),
    .id_dest(id_dest), .id_load(id_load), .id_branch(id_branch),
    .stall(stall_nf), .stall_cnt(cnt_nf)
  );

  hazard_scoreboard #(.REG_W(3), .DEPTH(3), .FWD_EN(1), .BR_BUBBLES(2)) u_fw (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr),
    .id_dest(id_dest), .id_load(id_load), .id_branch(id_branch),
    .stall(stall_fw), .stall_cnt(cnt_fw)
  );

  hazard_scoreboard #(.REG_W(3), .DEPTH(3), .FWD_EN(0), .BR_BUBBLES(15)) u_br (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr),
    .id_dest(id_dest), .id_load(id_load), .id_branch(id_branch),
    .stall(stall_br), .stall_cnt(cnt_br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Commit the previous cycle at the rising edge, drive the new decode slot,
  // then park at the falling edge so outputs are sampled mid-cycle.
  task automatic applyStimulus(input logic v, input logic [2:0] rs,
                               input logic urs, input logic [2:0] rt,
                               input logic urt, input logic wr,
                               input logic [2:0] dest, input logic ld,
                               input logic br);
    @(posedge clk);
    #1;
    id_valid  = v;
    id_rs     = rs;
    id_use_rs = urs;
    id_rt     = rt;
    id_use_rt = urt;
    id_wr     = wr;
    id_dest   = dest;
    id_load   = ld;
    id_branch = br;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    id_valid   = 1'b0;
    id_rs      = 3'd0;
    id_rt      = 3'd0;
    id_use_rs  = 1'b0;
    id_use_rt  = 1'b0;
    id_wr      = 1'b0;
    id_dest    = 3'd0;
    id_load    = 1'b0;
    id_branch  = 1'b0;

    #2;
    checkOutput("rst_stall", {15'd0, stall_nf}, 16'd0);
    checkOutput("rst_cnt", cnt_nf, 16'd0);
    id_valid  = 1'b1;
    id_use_rs = 1'b1;
    #1;
    checkOutput("rst_valid_nostall", {15'd0, stall_nf}, 16'd0);
    @(negedge clk);
    id_valid  = 1'b0;
    id_use_rs = 1'b0;
    rst       = 1'b0;

    // Non-forwarding: writer R3 then reader rs=R3 waits out EX, MEM, WB.
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    checkOutput("raw_c0", {15'd0, stall_nf}, 16'd0);
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("raw_c1", {15'd0, stall_nf}, 16'd1);
    checkOutput("fwd_alu_c1", {15'd0, stall_fw}, 16'd0);
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("raw_c2", {15'd0, stall_nf}, 16'd1);
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("raw_c3_wb", {15'd0, stall_nf}, 16'd1);
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("raw_c4", {15'd0, stall_nf}, 16'd0);
    checkOutput("raw_cnt", cnt_nf, 16'd3);
    checkOutput("fwd_alu_cnt", cnt_fw, 16'd0);
    idle();

    // Load to R5 then reader rt=R5: one bubble with forwarding, three without.
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
    checkOutput("ld_c0", {15'd0, stall_fw}, 16'd0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("ldu_fw_c1", {15'd0, stall_fw}, 16'd1);
    checkOutput("ldu_nf_c1", {15'd0, stall_nf}, 16'd1);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("ldu_fw_c2", {15'd0, stall_fw}, 16'd0);
    checkOutput("ldu_nf_c2", {15'd0, stall_nf}, 16'd1);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("ldu_nf_c4", {15'd0, stall_nf}, 16'd0);
    checkOutput("ldu_fw_cnt", cnt_fw, 16'd1);
    checkOutput("ldu_nf_cnt", cnt_nf, 16'd6);

    // Bubbles and unused sources never stall; WB-stage writer still does.
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("nop_match", {15'd0, stall_nf}, 16'd0);
    applyStimulus(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("unused_match", {15'd0, stall_nf}, 16'd0);
    applyStimulus(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("wb_match", {15'd0, stall_nf}, 16'd1);
    applyStimulus(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("wb_retired", {15'd0, stall_nf}, 16'd0);
    checkOutput("wb_cnt", cnt_nf, 16'd7);

    // Self-write does not stall; register 0 is an ordinary tracked register.
    applyStimulus(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    checkOutput("self_write", {15'd0, stall_nf}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      checkOutput($sformatf("r0_c%0d", i), {15'd0, stall_nf},
                  (i < 3) ? 16'd1 : 16'd0);
    end
    checkOutput("r0_cnt", cnt_nf, 16'd10);

    // Accepted branch: two bubbles afterwards.
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    checkOutput("br_c0", {15'd0, stall_nf}, 16'd0);
    idle();
    checkOutput("br_c1", {15'd0, stall_nf}, 16'd1);
    checkOutput("br_fw_c1", {15'd0, stall_fw}, 16'd1);
    idle();
    checkOutput("br_c2", {15'd0, stall_nf}, 16'd1);
    idle();
    checkOutput("br_c3", {15'd0, stall_nf}, 16'd0);
    checkOutput("br_fw_cnt", cnt_fw, 16'd3);

    // Branch held by a data hazard only arms its bubbles on acceptance.
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      checkOutput($sformatf("hbr_c%0d", i + 1), {15'd0, stall_nf},
                  (i < 3) ? 16'd1 : 16'd0);
    end
    idle();
    checkOutput("hbr_c5", {15'd0, stall_nf}, 16'd1);
    idle();
    checkOutput("hbr_c6", {15'd0, stall_nf}, 16'd1);
    idle();
    checkOutput("hbr_c7", {15'd0, stall_nf}, 16'd0);
    checkOutput("hbr_cnt", cnt_nf, 16'd17);

    // Reset mid-stall drops stall immediately and forgets the writer.
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("mid_pre", {15'd0, stall_nf}, 16'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_stall", {15'd0, stall_nf}, 16'd0);
    checkOutput("mid_rst_cnt", cnt_nf, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_post", {15'd0, stall_nf}, 16'd0);

    // Back-to-back branches with 15 bubbles keep stall high 15 of 16 cycles.
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    repeat (70400) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_cnt", cnt_br, 16'hFFFF);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("sat_rst_cnt", cnt_br, 16'd0);
    checkOutput("sat_rst_stall", {15'd0, stall_br}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
